mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_signfix.sv | 13 +
 rtl/mult_div_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states,
// iteration datapath select and small op-decoding helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULTU = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_DIVU  = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    typedef enum logic {
        ALU_MUL = 1'b0,
        ALU_DIV = 1'b1
    } alu_sel_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIVU) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate: yields |a| on the way in when neg_i is
// the operand sign, and restores the result sign on the way out.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers: one
// shift-add or restoring-divide step per cycle, sign correction in FIX.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    alu_sel_e         sel_q, sel_d;
    logic             negx_q, negx_d;
    logic             negy_q, negy_d;
    logic             yzero_q, yzero_d;
    logic [WIDTH-1:0] xsave_q, xsave_d;
    logic [WIDTH-1:0] ymag_q, ymag_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             is_signed_s;
    logic [WIDTH-1:0] xmag_s, ymag_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH-1:0] div_diff_s;
    logic             div_ge_s;

    assign is_signed_s = op_is_signed(op);

    mdu_signfix #(.W(WIDTH)) u_abs_x (.a_i(x), .neg_i(is_signed_s & x[WIDTH-1]), .y_o(xmag_s));
    mdu_signfix #(.W(WIDTH)) u_abs_y (.a_i(y), .neg_i(is_signed_s & y[WIDTH-1]), .y_o(ymag_s));

    mdu_signfix #(.W(2*WIDTH)) u_fix_prod (
        .a_i({acc_hi_q, acc_lo_q}), .neg_i(negx_q ^ negy_q), .y_o(prod_s));
    mdu_signfix #(.W(WIDTH)) u_fix_quo (.a_i(acc_lo_q), .neg_i(negx_q ^ negy_q), .y_o(quo_s));
    mdu_signfix #(.W(WIDTH)) u_fix_rem (.a_i(acc_hi_q), .neg_i(negx_q), .y_o(rem_s));

    // Multiply keeps the partial product in acc_hi and the unconsumed multiplier bits in acc_lo;
    // divide keeps the partial remainder in acc_hi and shifts quotient bits into acc_lo.
    assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, ymag_q} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, ymag_q});
    assign div_diff_s  = WIDTH'(div_shift_s - {1'b0, ymag_q});

    // Next-state, iteration datapath and HI/LO update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        negx_d   = negx_q;
        negy_d   = negy_q;
        yzero_d  = yzero_q;
        xsave_d  = xsave_q;
        ymag_d   = ymag_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV: begin
                            state_d  = ST_CALC;
                            busy_d   = 1'b1;
                            cnt_d    = '0;
                            sel_d    = op_is_div(op) ? ALU_DIV : ALU_MUL;
                            negx_d   = is_signed_s & x[WIDTH-1];
                            negy_d   = is_signed_s & y[WIDTH-1];
                            yzero_d  = (y == '0);
                            xsave_d  = x;
                            ymag_d   = ymag_s;
                            acc_hi_d = '0;
                            acc_lo_d = xmag_s;
                        end
                        MDU_MTHI: hi_d = x;
                        MDU_MTLO: lo_d = x;
                        default:  state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (sel_q == ALU_DIV) begin
                        acc_hi_d = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge_s};
                    end else begin
                        {acc_hi_d, acc_lo_d} = {mul_sum_s, acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (flush) begin
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    if (sel_q == ALU_MUL) begin
                        {hi_d, lo_d} = prod_s;
                    end else if (yzero_q) begin
                        // Divide by zero: all-ones quotient, dividend passed through untouched.
                        lo_d = '1;
                        hi_d = xsave_q;
                    end else begin
                        lo_d = quo_s;
                        hi_d = rem_s;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= ALU_MUL;
            negx_q   <= 1'b0;
            negy_q   <= 1'b0;
            yzero_q  <= 1'b0;
            xsave_q  <= '0;
            ymag_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            negx_q   <= negx_d;
            negy_q   <= negy_d;
            yzero_q  <= yzero_d;
            xsave_q  <= xsave_d;
            ymag_q   <= ymag_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
